// File: rtl/dm_arbiter.sv
// dm_arbiter
// Round-robin arbiter sharing one single-port, registered-read data memory (DM)
// between N_CORE processor cores. One access is in flight at a time:
// IDLE (arbitrate) -> ACCESS (DM performs the access) -> RDATA (reads only).
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   req, we          per-core request (level) and write(1)/read(0) select
//   addr, wdata      per-core address / write data, core i at [i*W +: W]
//   lock             per-core bus-lock request (used only with DM_ARB_LOCK_EN)
//   dm_out           DM read data, valid one cycle after the address
//   gnt              one-hot grant pulse
//   rvalid, rdata    one-hot read-valid pulse and broadcast read data
//   dm_en            DM write enable, high only during ACCESS of a write
//   dm_addr,dm_wdata DM address / write data, held between accesses
//   busy             high whenever the arbiter is not in IDLE
//
// Optional feature: define DM_ARB_LOCK_EN to let a core that finishes an
// access with lock high keep exclusive ownership of the DM (atomic RMW).
// Without it the lock port is ignored.

module dm_arbiter #(
  parameter int N_CORE = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CORE-1:0]        req,
  input  logic [N_CORE-1:0]        we,
  input  logic [N_CORE*ADDR_W-1:0] addr,
  input  logic [N_CORE*DATA_W-1:0] wdata,
  input  logic [N_CORE-1:0]        lock,
  input  logic [DATA_W-1:0]        dm_out,
  output logic [N_CORE-1:0]        gnt,
  output logic [N_CORE-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     dm_en,
  output logic [ADDR_W-1:0]        dm_addr,
  output logic [DATA_W-1:0]        dm_wdata,
  output logic                     busy
);

  localparam int IDX_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;
  localparam logic [N_CORE-1:0] ONE = {{(N_CORE-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CORE - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t              state, state_nxt;
  logic [N_CORE-1:0]   gnt_nxt, rvalid_nxt;
  logic [DATA_W-1:0]   rdata_nxt, dm_wdata_nxt;
  logic [ADDR_W-1:0]   dm_addr_nxt;
  logic                dm_en_nxt;
  logic [IDX_W-1:0]    last, last_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt;
  logic [N_CORE-1:0]   cand;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    idx;
  logic                lock_hold;

`ifdef DM_ARB_LOCK_EN
  logic locked, locked_nxt;

  // The mask is live only while the owner keeps lock asserted; the first IDLE
  // cycle with lock low falls straight back to normal round-robin.
  assign lock_hold = locked && lock[owner];
  assign cand      = lock_hold ? (req & (ONE << owner)) : req;
`else
  logic unused_lock;

  assign unused_lock = ^lock;
  assign lock_hold   = 1'b0;
  assign cand        = req;
`endif

  assign busy = (state != IDLE);

  // Round-robin search starting just after the most recent winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= N_CORE; k++) begin
      idx = IDX_W'((int'(last) + k) % N_CORE);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = '0;
    rvalid_nxt   = '0;
    rdata_nxt    = rdata;
    dm_en_nxt    = 1'b0;
    dm_addr_nxt  = dm_addr;
    dm_wdata_nxt = dm_wdata;
    last_nxt     = last;
    owner_nxt    = owner;
`ifdef DM_ARB_LOCK_EN
    locked_nxt   = locked;
`endif
    case (state)
      IDLE: begin
`ifdef DM_ARB_LOCK_EN
        if (locked && !lock[owner]) locked_nxt = 1'b0;
`endif
        if (win_found) begin
          state_nxt    = ACCESS;
          gnt_nxt      = ONE << win_idx;
          dm_addr_nxt  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
          dm_wdata_nxt = wdata[int'(win_idx)*DATA_W +: DATA_W];
          dm_en_nxt    = we[win_idx];
          owner_nxt    = win_idx;
          if (!lock_hold) last_nxt = win_idx;
        end
      end
      // dm_en doubles as the "this access is a write" flag.
      ACCESS: begin
        if (dm_en) begin
          state_nxt = IDLE;
`ifdef DM_ARB_LOCK_EN
          locked_nxt = lock[owner];
`endif
        end else begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        state_nxt  = IDLE;
        rdata_nxt  = dm_out;
        rvalid_nxt = ONE << owner;
`ifdef DM_ARB_LOCK_EN
        locked_nxt = lock[owner];
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      dm_en    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      last     <= LAST_RST;
      owner    <= '0;
`ifdef DM_ARB_LOCK_EN
      locked   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rvalid   <= rvalid_nxt;
      rdata    <= rdata_nxt;
      dm_en    <= dm_en_nxt;
      dm_addr  <= dm_addr_nxt;
      dm_wdata <= dm_wdata_nxt;
      last     <= last_nxt;
      owner    <= owner_nxt;
`ifdef DM_ARB_LOCK_EN
      locked   <= locked_nxt;
`endif
    end
  end

endmodule
